// File: rtl/arbitro_divisor_pkg.sv
// Shared types and constants for the divider arbiter: FSM states, error codes
// and the operand width of the 7-bit restoring divider.
package divisor_pkg;

  localparam int W_DATA = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

endpackage

// File: rtl/arbitro_divisor_if.sv
// Bus bundle between the requesters, the arbiter and the shared divider.
// Handshake: a requester raises req[i] with its operands and holds them until
// ack[i] pulses for one cycle; that pulse carries the result and completes the
// transaction. req[i] still high in the cycle after ack[i] is a new request.
interface arbitro_divisor_if
  import divisor_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*W_DATA-1:0] op_dividendo;
  logic [N_REQ*W_DATA-1:0] op_divisor;
  logic [N_REQ-1:0]        ack;
  logic [W_DATA-1:0]       res_cociente;
  logic [W_DATA-1:0]       res_resto;
  logic [1:0]              res_err;
  logic                    busy;
  logic [2:0]              grant_id;
  logic                    div_start;
  logic [W_DATA-1:0]       div_dividendo;
  logic [W_DATA-1:0]       div_divisor;
  logic [W_DATA-1:0]       div_cociente;
  logic [W_DATA-1:0]       div_resto;
  logic                    div_done;

  modport slave (
    input  req, op_dividendo, op_divisor, div_cociente, div_resto, div_done,
    output ack, res_cociente, res_resto, res_err, busy, grant_id,
           div_start, div_dividendo, div_divisor
  );

  modport master (
    output req, op_dividendo, op_divisor, div_cociente, div_resto, div_done,
    input  ack, res_cociente, res_resto, res_err, busy, grant_id,
           div_start, div_dividendo, div_divisor
  );

endinterface

// File: rtl/arbitro_divisor_rr.sv
// Combinational round-robin picker: first requester found searching upward,
// with wrap, starting just after the last served index.
module arbitro_rr #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       winner
);

  int best_off;

  // Distance from ptr+1 to j modulo N_REQ; the smallest distance wins.
  always_comb begin
    valid    = |req;
    winner   = '0;
    best_off = N_REQ;
    for (int j = 0; j < N_REQ; j++) begin
      if (req[j] && (((j - int'(ptr) - 1 + 2 * N_REQ) % N_REQ) < best_off)) begin
        best_off = (j - int'(ptr) - 1 + 2 * N_REQ) % N_REQ;
        winner   = 3'(j);
      end
    end
  end

endmodule

// File: rtl/arbitro_divisor.sv
// Shares one 7-bit restoring divider among N_REQ requesters: round-robin grant,
// operand latch, start pulse, bounded wait for done, one-hot ack with result.
module arbitro_divisor
  import divisor_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic               clk,
  input  logic               rst,
  arbitro_divisor_if.slave   bus,
  output state_t             state_dbg
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        grant_q, grant_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [W_DATA-1:0] coc_q, coc_d;
  logic [W_DATA-1:0] rem_q, rem_d;
  logic [W_DATA-1:0] dvd_q, dvd_d;
  logic [W_DATA-1:0] dvs_q, dvs_d;
  err_t              err_q, err_d;

  logic              rr_valid;
  logic [2:0]        rr_winner;
  logic [W_DATA-1:0] sel_dvd, sel_dvs;

  arbitro_rr #(.N_REQ(N_REQ)) u_rr (
    .req    (bus.req),
    .ptr    (ptr_q),
    .valid  (rr_valid),
    .winner (rr_winner)
  );

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rr_winner == 3'(j)) begin
        sel_dvd = bus.op_dividendo[j*W_DATA +: W_DATA];
        sel_dvs = bus.op_divisor[j*W_DATA +: W_DATA];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'(N_REQ - 1);
      grant_q <= '0;
      wd_q    <= '0;
      coc_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
      coc_q   <= coc_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wd_d    = wd_q;
    coc_d   = coc_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_winner;
          dvd_d   = sel_dvd;
          dvs_d   = sel_dvs;
          // A zero divisor is answered here; the divider never sees it.
          if (sel_dvs == '0) begin
            coc_d   = '1;
            rem_d   = sel_dvd;
            err_d   = ERR_DIV0;
            state_d = RESP;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (bus.div_done) begin
          coc_d   = bus.div_cociente;
          rem_d   = bus.div_resto;
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          coc_d   = '0;
          rem_d   = '0;
          err_d   = ERR_TIMEOUT;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack           = (state_q == RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign bus.res_cociente  = coc_q;
  assign bus.res_resto     = rem_q;
  assign bus.res_err       = err_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.grant_id      = grant_q;
  assign bus.div_start     = (state_q == LAUNCH);
  assign bus.div_dividendo = dvd_q;
  assign bus.div_divisor   = dvs_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_arbitro_divisor.sv
// Directed bench for arbitro_divisor with a cycle-accurate divider stand-in
// (start -> done ten cycles later) that can be told to withhold done.
module tb_arbitro_divisor;
  import divisor_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 31;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t state_dbg;
  int     checks = 0;
  int     errors = 0;
  int     start_cnt = 0;
  logic   suppress = 1'b0;

  arbitro_divisor_if #(.N_REQ(N_REQ)) bus();

  arbitro_divisor #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Divider stand-in: INIT, 7 STEPs, FIN, then done.
  logic [3:0] m_cnt;
  logic [6:0] m_q, m_r;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 4'd0;
      m_q   <= 7'd0;
      m_r   <= 7'd0;
    end else if (bus.div_start) begin
      m_cnt <= 4'd10;
      m_q   <= (bus.div_divisor != 0) ? bus.div_dividendo / bus.div_divisor : 7'd0;
      m_r   <= (bus.div_divisor != 0) ? bus.div_dividendo % bus.div_divisor : 7'd0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 4'd1;
    end
  end
  assign bus.div_done     = (m_cnt == 4'd1) && !suppress;
  assign bus.div_cociente = m_q;
  assign bus.div_resto    = m_r;

  always @(posedge clk) if (bus.div_start) start_cnt++;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int idx, input logic [6:0] dvd, input logic [6:0] dvs);
    bus.op_dividendo[idx*7 +: 7] = dvd;
    bus.op_divisor[idx*7 +: 7]   = dvs;
  endtask

  task automatic wait_ack(input int max_cyc, output int n);
    n = 0;
    while (bus.ack == '0 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    bus.req = '0;
    bus.op_dividendo = '0;
    bus.op_divisor = '0;
    rst = 1'b0;
    step(2);
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    checks++; if ({bus.ack, bus.busy, bus.div_start} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", {bus.ack, bus.busy, bus.div_start}); end
    checks++; if ({bus.grant_id, bus.res_err} !== 5'b0) begin errors++; $display("FAIL reset_grant_err: got %b expected 0", {bus.grant_id, bus.res_err}); end
    checks++; if ({bus.res_cociente, bus.res_resto, bus.div_dividendo, bus.div_divisor} !== 28'b0) begin errors++; $display("FAIL reset_data: got %h expected 0", {bus.res_cociente, bus.res_resto, bus.div_dividendo, bus.div_divisor}); end
    rst = 1'b1;
    step(2);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single;
    int n, s0;
    s0 = start_cnt;
    set_op(0, 7'd100, 7'd7);
    bus.req = 4'b0001;
    step(1);
    checks++; if (bus.div_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", bus.div_start); end
    checks++; if (bus.grant_id !== 3'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", bus.grant_id); end
    checks++; if ({bus.div_dividendo, bus.div_divisor} !== {7'd100, 7'd7}) begin errors++; $display("FAIL single_operands: got %0d/%0d expected 100/7", bus.div_dividendo, bus.div_divisor); end
    wait_ack(40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL single_latency: got %0d expected 11", n); end
    checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b expected 0001", bus.ack); end
    checks++; if ({bus.res_cociente, bus.res_resto, bus.res_err} !== {7'd14, 7'd2, 2'b00}) begin errors++; $display("FAIL single_result: got q=%0d r=%0d e=%b expected q=14 r=2 e=00", bus.res_cociente, bus.res_resto, bus.res_err); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_start_count: got %0d expected 1", start_cnt - s0); end
    bus.req = '0;
    step(1);
    checks++; if ({bus.ack, bus.busy} !== 5'b0) begin errors++; $display("FAIL single_after: got %b expected 0", {bus.ack, bus.busy}); end
    checks++; if ({bus.res_cociente, bus.res_resto} !== {7'd14, 7'd2}) begin errors++; $display("FAIL single_hold: got q=%0d r=%0d expected 14/2", bus.res_cociente, bus.res_resto); end
  endtask

  task automatic test_div0;
    int s0;
    s0 = start_cnt;
    set_op(2, 7'd45, 7'd0);
    bus.req = 4'b0100;
    step(1);
    checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL div0_ack: got %b expected 0100", bus.ack); end
    checks++; if ({bus.res_cociente, bus.res_resto, bus.res_err} !== {7'h7F, 7'd45, 2'b01}) begin errors++; $display("FAIL div0_result: got q=%0d r=%0d e=%b expected q=127 r=45 e=01", bus.res_cociente, bus.res_resto, bus.res_err); end
    checks++; if (bus.grant_id !== 3'd2) begin errors++; $display("FAIL div0_grant: got %0d expected 2", bus.grant_id); end
    bus.req = '0;
    step(2);
    checks++; if (start_cnt - s0 !== 0) begin errors++; $display("FAIL div0_no_start: got %0d expected 0", start_cnt - s0); end
  endtask

  task automatic test_round_robin;
    int n;
    int exp_id[5]         = '{0, 1, 2, 3, 0};
    logic [6:0] exp_q[4]  = '{7'd14, 7'd8, 7'd12, 7'd3};
    logic [6:0] exp_r[4]  = '{7'd2, 7'd2, 7'd7, 7'd0};
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    set_op(0, 7'd100, 7'd7);
    set_op(1, 7'd50, 7'd6);
    set_op(2, 7'd127, 7'd10);
    set_op(3, 7'd9, 7'd3);
    bus.req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, n);
      checks++; if (n !== ((k == 0) ? 11 : 12)) begin errors++; $display("FAIL rr_period_%0d: got %0d expected %0d", k, n, (k == 0) ? 11 : 12); end
      checks++; if (bus.ack !== (4'b0001 << exp_id[k])) begin errors++; $display("FAIL rr_ack_%0d: got %b expected port %0d", k, bus.ack, exp_id[k]); end
      checks++; if (bus.grant_id !== 3'(exp_id[k])) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", k, bus.grant_id, exp_id[k]); end
      checks++; if ({bus.res_cociente, bus.res_resto, bus.res_err} !== {exp_q[exp_id[k]], exp_r[exp_id[k]], 2'b00}) begin errors++; $display("FAIL rr_result_%0d: got q=%0d r=%0d e=%b expected q=%0d r=%0d e=00", k, bus.res_cociente, bus.res_resto, bus.res_err, exp_q[exp_id[k]], exp_r[exp_id[k]]); end
      if (k == 4) bus.req = '0;
      step(1);
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_timeout;
    int n;
    suppress = 1'b1;
    set_op(3, 7'd20, 7'd4);
    bus.req = 4'b1000;
    step(1);
    checks++; if (bus.div_start !== 1'b1) begin errors++; $display("FAIL to_launch: got %b expected 1", bus.div_start); end
    wait_ack(100, n);
    checks++; if (n !== TIMEOUT + 1) begin errors++; $display("FAIL to_latency: got %0d expected %0d", n, TIMEOUT + 1); end
    checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL to_ack: got %b expected 1000", bus.ack); end
    checks++; if ({bus.res_cociente, bus.res_resto, bus.res_err} !== {7'd0, 7'd0, 2'b10}) begin errors++; $display("FAIL to_result: got q=%0d r=%0d e=%b expected q=0 r=0 e=10", bus.res_cociente, bus.res_resto, bus.res_err); end
    bus.req = '0;
    suppress = 1'b0;
    step(1);
    set_op(1, 7'd20, 7'd4);
    bus.req = 4'b0010;
    step(1);
    wait_ack(40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL to_next_latency: got %0d expected 11", n); end
    checks++; if ({bus.ack, bus.res_cociente, bus.res_resto, bus.res_err} !== {4'b0010, 7'd5, 7'd0, 2'b00}) begin errors++; $display("FAIL to_next_result: got ack=%b q=%0d r=%0d e=%b expected ack=0010 q=5 r=0 e=00", bus.ack, bus.res_cociente, bus.res_resto, bus.res_err); end
    bus.req = '0;
    step(1);
  endtask

  task automatic test_reset_mid_wait;
    int n;
    set_op(1, 7'd60, 7'd5);
    bus.req = 4'b0010;
    step(1);
    step(5);
    checks++; if (state_dbg !== WAIT) begin errors++; $display("FAIL rmw_in_wait: got %0d expected %0d", state_dbg, WAIT); end
    rst = 1'b0;
    #1;
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rmw_state: got %0d expected %0d", state_dbg, IDLE); end
    checks++; if ({bus.ack, bus.busy, bus.div_start, bus.grant_id, bus.res_err} !== 11'b0) begin errors++; $display("FAIL rmw_ctrl: got %b expected 0", {bus.ack, bus.busy, bus.div_start, bus.grant_id, bus.res_err}); end
    checks++; if ({bus.res_cociente, bus.res_resto, bus.div_dividendo, bus.div_divisor} !== 28'b0) begin errors++; $display("FAIL rmw_data: got %h expected 0", {bus.res_cociente, bus.res_resto, bus.div_dividendo, bus.div_divisor}); end
    bus.req = '0;
    step(1);
    rst = 1'b1;
    step(1);
    set_op(0, 7'd127, 7'd1);
    bus.req = 4'b0001;
    step(1);
    wait_ack(40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL rmw_latency: got %0d expected 11", n); end
    checks++; if ({bus.ack, bus.res_cociente, bus.res_resto, bus.res_err} !== {4'b0001, 7'd127, 7'd0, 2'b00}) begin errors++; $display("FAIL rmw_result: got ack=%b q=%0d r=%0d e=%b expected ack=0001 q=127 r=0 e=00", bus.ack, bus.res_cociente, bus.res_resto, bus.res_err); end
    bus.req = '0;
    step(1);
  endtask

  task automatic test_operand_change;
    int n;
    set_op(1, 7'd30, 7'd4);
    bus.req = 4'b0010;
    step(1);
    set_op(1, 7'd99, 7'd9);
    step(3);
    checks++; if ({bus.div_dividendo, bus.div_divisor} !== {7'd30, 7'd4}) begin errors++; $display("FAIL opchg_operands: got %0d/%0d expected 30/4", bus.div_dividendo, bus.div_divisor); end
    set_op(1, 7'd5, 7'd0);
    wait_ack(40, n);
    checks++; if ({bus.ack, bus.res_cociente, bus.res_resto, bus.res_err} !== {4'b0010, 7'd7, 7'd2, 2'b00}) begin errors++; $display("FAIL opchg_result: got ack=%b q=%0d r=%0d e=%b expected ack=0010 q=7 r=2 e=00", bus.ack, bus.res_cociente, bus.res_resto, bus.res_err); end
    bus.req = '0;
    step(2);
  endtask

  initial begin
    bus.req = '0;
    bus.op_dividendo = '0;
    bus.op_divisor = '0;
    test_reset();
    test_single();
    test_div0();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    test_operand_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
